// File: rtl/keypad_entry.sv
// Keypad entry front end: accumulates BCD digits into a binary operand and
// turns command keys into level-toggle events for the execution module.
module keypad_entry #(
    parameter int MAX_DIGITS = 4,
    parameter int NUM_W      = 14
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             keyValid,
    input  logic [3:0]       keyCode,
    output logic             keyReady,
    output logic [NUM_W-1:0] inNumbers,
    output logic             store,
    output logic             update,
    output logic             show,
    output logic             reset,
    output logic             errIn,
    output logic [2:0]       digitCount
);

    typedef enum logic [1:0] {EMPTY, ENTRY, CMD, ERROR} state_e;
    typedef enum logic [1:0] {CMD_STORE, CMD_UPDATE, CMD_SHOW, CMD_CLEAR} cmd_e;

    localparam logic [3:0] KEY_STORE     = 4'd10;
    localparam logic [3:0] KEY_UPDATE    = 4'd11;
    localparam logic [3:0] KEY_SHOW      = 4'd12;
    localparam logic [3:0] KEY_CLEAR     = 4'd13;
    localparam logic [3:0] KEY_BACKSPACE = 4'd14;

    state_e                          state_q, state_d;
    cmd_e                            cmd_q, cmd_d;
    logic [MAX_DIGITS-1:0][3:0]      digits_q, digits_d;
    logic [2:0]                      count_q, count_d;
    logic [NUM_W-1:0]                num_q, num_d;
    logic [3:0]                      tog_q, tog_d;
    logic                            err_q, err_d;
    logic                            ready_q, ready_d;
    logic                            accept;

    assign accept = keyValid && ready_q;

    // Horner evaluation of the BCD buffer, most significant digit first.
    always_comb begin
        num_d = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            num_d = num_d * NUM_W'(10) + NUM_W'(digits_q[i]);
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        cmd_d    = cmd_q;
        digits_d = digits_q;
        count_d  = count_q;
        tog_d    = tog_q;
        err_d    = (state_q == ERROR);

        if (state_q == CMD) begin
            tog_d[cmd_q] = ~tog_q[cmd_q];
            state_d      = EMPTY;
            count_d      = '0;
        end else if (accept) begin
            if (keyCode == KEY_CLEAR) begin
                cmd_d    = CMD_CLEAR;
                state_d  = CMD;
                digits_d = '0;
                count_d  = '0;
            end else if (state_q == ERROR) begin
                // Locked: consume and ignore everything but clear.
            end else if (keyCode <= 4'd9) begin
                if (state_q == EMPTY) begin
                    digits_d    = '0;
                    digits_d[0] = keyCode;
                    count_d     = 3'd1;
                    state_d     = ENTRY;
                end else if (count_q < 3'(MAX_DIGITS)) begin
                    digits_d = {digits_q[MAX_DIGITS-2:0], keyCode};
                    count_d  = count_q + 3'd1;
                end else begin
                    state_d = ERROR;
                end
            end else if (keyCode == KEY_STORE) begin
                cmd_d   = CMD_STORE;
                state_d = CMD;
            end else if (keyCode == KEY_UPDATE) begin
                cmd_d   = CMD_UPDATE;
                state_d = CMD;
            end else if (keyCode == KEY_SHOW) begin
                cmd_d   = CMD_SHOW;
                state_d = CMD;
            end else if (keyCode == KEY_BACKSPACE) begin
                if (state_q == ENTRY) begin
                    digits_d = {4'd0, digits_q[MAX_DIGITS-1:1]};
                    count_d  = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        state_d = EMPTY;
                    end
                end
            end else begin
                state_d = ERROR;
            end
        end

        ready_d = (state_d != CMD);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= EMPTY;
            cmd_q    <= CMD_STORE;
            // NOTE: the digit buffer is only a few flops and its contents are
            // visible on inNumbers, so it is reset like any other state.
            digits_q <= '0;
            count_q  <= '0;
            num_q    <= '0;
            tog_q    <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            num_q    <= num_d;
            tog_q    <= tog_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign keyReady   = ready_q;
    assign inNumbers  = num_q;
    assign store      = tog_q[CMD_STORE];
    assign update     = tog_q[CMD_UPDATE];
    assign show       = tog_q[CMD_SHOW];
    assign reset      = tog_q[CMD_CLEAR];
    assign errIn      = err_q;
    assign digitCount = count_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry; inputs change #1 after the
// rising edge and outputs are sampled at the same point.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rstN;
    logic        keyValid;
    logic [3:0]  keyCode;
    logic        keyReady;
    logic [13:0] inNumbers;
    logic        store, update, show, reset;
    logic        errIn;
    logic [2:0]  digitCount;

    int checks = 0;
    int errors = 0;

    keypad_entry #(.MAX_DIGITS(4), .NUM_W(14)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .keyValid   (keyValid),
        .keyCode    (keyCode),
        .keyReady   (keyReady),
        .inNumbers  (inNumbers),
        .store      (store),
        .update     (update),
        .show       (show),
        .reset      (reset),
        .errIn      (errIn),
        .digitCount (digitCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] code);
        keyValid = 1'b1;
        keyCode  = code;
        @(posedge clk);
        #1;
        keyValid = 1'b0;
        keyCode  = 4'd0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Toggle lines packed as {store, update, show, reset}.
    function automatic logic [3:0] togs();
        return {store, update, show, reset};
    endfunction

    initial begin
        rstN     = 1'b0;
        keyValid = 1'b0;
        keyCode  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_num",   inNumbers, 0);
        check("rst_togs",  togs(), 4'b0000);
        check("rst_err",   errIn, 0);
        check("rst_count", digitCount, 0);
        check("rst_ready", keyReady, 1);
        rstN = 1'b1;
        idle();

        // Digits 1 2 5 0
        key(4'd1);
        check("d1_count", digitCount, 1);
        key(4'd2);
        key(4'd5);
        key(4'd0);
        check("d4_count", digitCount, 4);
        check("d4_num_lag", inNumbers, 125);
        idle();
        check("d4_num", inNumbers, 1250);
        check("d4_togs", togs(), 4'b0000);
        check("d4_err", errIn, 0);

        // Store: toggle one cycle after acceptance, keyReady low in between
        key(4'd10);
        check("st_ready_lo", keyReady, 0);
        check("st_not_yet", store, 0);
        idle();
        check("st_store", store, 1);
        check("st_ready_hi", keyReady, 1);
        check("st_count", digitCount, 0);
        check("st_num_kept", inNumbers, 1250);

        key(4'd2);
        check("d2_count", digitCount, 1);
        idle();
        check("d2_num", inNumbers, 2);
        key(4'd11);
        idle();
        check("upd_togs", togs(), 4'b1100);

        // Store held through the keyReady=0 cycle is accepted exactly once later
        keyValid = 1'b1;
        keyCode  = 4'd10;
        @(posedge clk); #1;
        check("hold_ready_lo", keyReady, 0);
        @(posedge clk); #1;
        check("hold_store_a", store, 0);
        check("hold_ready_hi", keyReady, 1);
        @(posedge clk); #1;
        keyValid = 1'b0;
        check("hold_ready_lo2", keyReady, 0);
        idle();
        check("hold_store_b", store, 1);
        idle();
        check("hold_store_c", store, 1);

        // Overflow: 9 9 9 9 9
        repeat (4) key(4'd9);
        key(4'd9);
        check("ovf_err_lag", errIn, 0);
        idle();
        check("ovf_err", errIn, 1);
        check("ovf_num", inNumbers, 9999);
        check("ovf_count", digitCount, 4);
        key(4'd12);
        check("err_ready", keyReady, 1);
        idle();
        key(4'd3);
        idle();
        check("err_togs", togs(), 4'b1100);
        check("err_stays", errIn, 1);
        check("err_num", inNumbers, 9999);
        key(4'd13);
        check("clr_ready_lo", keyReady, 0);
        check("clr_count", digitCount, 0);
        idle();
        check("clr_togs", togs(), 4'b1101);
        check("clr_err", errIn, 0);
        check("clr_num", inNumbers, 0);

        // Backspace: 4 5 6, then four backspaces
        key(4'd4);
        key(4'd5);
        key(4'd6);
        key(4'd14);
        check("bs1_num", inNumbers, 456);
        check("bs1_count", digitCount, 2);
        key(4'd14);
        check("bs2_num", inNumbers, 45);
        check("bs2_count", digitCount, 1);
        key(4'd14);
        check("bs3_num", inNumbers, 4);
        check("bs3_count", digitCount, 0);
        idle();
        check("bs3_num_z", inNumbers, 0);
        key(4'd14);
        idle();
        check("bs4_count", digitCount, 0);
        check("bs4_num", inNumbers, 0);
        check("bs4_err", errIn, 0);
        check("bs4_togs", togs(), 4'b1101);

        // Illegal code from EMPTY
        key(4'd15);
        idle();
        check("ill_err", errIn, 1);
        check("ill_togs", togs(), 4'b1101);
        key(4'd13);
        idle();
        check("ill_clr_err", errIn, 0);
        check("ill_clr_togs", togs(), 4'b1100);

        // Reset asserted in the CMD cycle after a show acceptance
        key(4'd7);
        key(4'd3);
        key(4'd12);
        rstN = 1'b0;
        #1;
        check("mr_num", inNumbers, 0);
        check("mr_togs", togs(), 4'b0000);
        check("mr_err", errIn, 0);
        check("mr_count", digitCount, 0);
        check("mr_ready", keyReady, 1);
        idle();
        rstN = 1'b1;
        idle();
        check("mr_show", show, 0);
        key(4'd1);
        idle();
        check("mr_d1_num", inNumbers, 1);
        check("mr_d1_count", digitCount, 1);
        check("mr_d1_show", show, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
